// File: rtl/result_mailbox.sv
// result_mailbox: watches a CPU write bus for the end-of-test mailbox write,
// reports pass/fail/timeout, counts writes and (optionally) logs them.
// Optional trace FIFO is built only when RESULT_MAILBOX_TRACE_EN is defined;
// without it the read-side ports are tied to their idle values.
module result_mailbox #(
  parameter logic [15:0] WATCH_ADDR = 16'h0030,
  parameter logic [7:0]  EXPECT     = 8'h9D,
  parameter logic [15:0] TIMEOUT    = 16'd220,
  parameter logic [15:0] LOG_LO     = 16'h0000,
  parameter logic [15:0] LOG_HI     = 16'h00FF
) (
  input  logic        ph1,
  input  logic        resetb,
  input  logic [15:0] adr,
  input  logic [7:0]  data,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  result,
  output logic [7:0]  wcount,
  input  logic        rd_en,
  output logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        ovf
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tout_q, tout_d;
  logic [7:0]  result_q, result_d;
  logic [7:0]  wcount_q, wcount_d;
  logic        wr_run_s;
  logic        watch_hit_s;

  // Writes only matter while the test is still running.
  assign wr_run_s    = (state_q == ST_RUN) & memwrite;
  assign watch_hit_s = wr_run_s & (adr == WATCH_ADDR);

  // Next-state, result capture and write counting; the mailbox write wins over the timeout.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    result_d = result_q;
    wcount_d = wcount_q;
    case (state_q)
      ST_RUN: begin
        cyc_d = cyc_q + 16'd1;
        if (watch_hit_s) begin
          result_d = data;
          if (data == EXPECT) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (cyc_q == TIMEOUT) begin
          state_d = ST_TOUT;
        end else begin
          state_d = ST_RUN;
        end
        if (memwrite) begin
          if (wcount_q != 8'hFF) begin
            wcount_d = wcount_q + 8'd1;
          end else begin
            wcount_d = wcount_q;
          end
        end else begin
          wcount_d = wcount_q;
        end
      end
      ST_PASS, ST_FAIL, ST_TOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    tout_d = (state_d == ST_TOUT);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      state_q  <= ST_RUN;
      cyc_q    <= 16'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tout_q   <= 1'b0;
      result_q <= 8'h00;
      wcount_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tout_q   <= tout_d;
      result_q <= result_d;
      wcount_q <= wcount_d;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = tout_q;
  assign result  = result_q;
  assign wcount  = wcount_q;

`ifdef RESULT_MAILBOX_TRACE_EN
  localparam logic [15:0] LOG_SPAN = LOG_HI - LOG_LO;

  logic [15:0] mem_q [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] off_s;
  logic        empty_s, full_s, push_s, pop_s, accept_s;

  // Window test as an unsigned offset so a zero lower bound needs no special case.
  assign off_s    = adr - LOG_LO;
  assign empty_s  = (cnt_q == 4'd0);
  assign full_s   = (cnt_q == 4'd8);
  assign push_s   = wr_run_s & (off_s <= LOG_SPAN);
  assign pop_s    = rd_en & ~empty_s;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign accept_s = push_s & (~full_s | pop_s);

  // Pointer, occupancy and sticky-overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + 3'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 3'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push_s && !accept_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO control registers with synchronous active-low reset.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; needs no reset because the read side is masked while empty.
  always_ff @(posedge ph1) begin
    if (resetb && accept_s) begin
      mem_q[wr_ptr_q] <= {adr[7:0], data};
    end
  end

  assign rd_addr = empty_s ? 8'h00 : mem_q[rd_ptr_q][15:8];
  assign rd_data = empty_s ? 8'h00 : mem_q[rd_ptr_q][7:0];
  assign empty   = empty_s;
  assign full    = full_s;
  assign ovf     = ovf_q;
`else
  logic unused_s;

  // Without the trace log the read side sits idle and rd_en has no effect.
  assign unused_s = ^{rd_en, LOG_LO, LOG_HI};
  assign rd_addr  = 8'h00;
  assign rd_data  = 8'h00;
  assign empty    = 1'b1;
  assign full     = 1'b0;
  assign ovf      = 1'b0;
`endif

endmodule

// File: doc/result_mailbox.md
RESULT_MAILBOX -- requirements
Module: result_mailbox

Interface
REQ-001 Parameter WATCH_ADDR, 16'h0030: memory address whose write ends the test.
REQ-002 Parameter EXPECT, 8'h9D: value a passing program writes to WATCH_ADDR.
REQ-003 Parameter TIMEOUT, 16'd220: ph1 cycles allowed after leaving reset before the test is declared failed.
REQ-004 Parameter LOG_LO / LOG_HI, 16'h0000 / 16'h00FF: inclusive address window of writes logged to the trace FIFO.
REQ-005 Port ph1, in, 1: sole clock; all state updates on its rising edge.
REQ-006 Port resetb, in, 1: synchronous, active-low reset, sampled on ph1 rising edge.
REQ-007 Port adr, in, 16: CPU memory bus address.
REQ-008 Port data, in, 8: CPU write data.
REQ-009 Port memwrite, in, 1: CPU write strobe, one cycle per write.
REQ-010 Port done, out, 1: test finished (pass, fail or timeout).
REQ-011 Port pass, out, 1: valid only while done=1; 1 = WATCH_ADDR received EXPECT.
REQ-012 Port timeout, out, 1: done was reached by cycle limit.
REQ-013 Port result, out, 8: value captured from the WATCH_ADDR write.
REQ-014 Port wcount, out, 8: number of CPU writes seen since reset, saturating.
REQ-015 Ports rd_en in 1, rd_addr out 8, rd_data out 8, empty out 1, full out 1, ovf out 1: trace FIFO read side.

Function
REQ-016 FSM states: RUN, PASS, FAIL, TOUT; PASS, FAIL and TOUT are terminal until reset.
REQ-017 RUN: memwrite=1 with adr==WATCH_ADDR captures data into result the same edge; next state PASS if data==EXPECT, otherwise FAIL.
REQ-018 RUN: cycle counter increments every cycle; when it reaches TIMEOUT with no WATCH_ADDR write, next state TOUT.
REQ-019 A WATCH_ADDR write on the same cycle the counter reaches TIMEOUT takes priority: PASS or FAIL, not TOUT.
REQ-020 done=1 in PASS/FAIL/TOUT; pass=1 only in PASS; timeout=1 only in TOUT; all outputs are registered and change one edge after the causing input.
REQ-021 Terminal states ignore further writes: result, wcount and the FIFO contents are frozen.
REQ-022 wcount increments on each memwrite=1 in RUN, including the WATCH_ADDR write, and saturates at 8'hFF.
REQ-023 Trace FIFO: 8 entries of {adr[7:0], data}; push on memwrite=1 in RUN when LOG_LO<=adr<=LOG_HI.
REQ-024 FIFO read is a show-ahead read: rd_addr/rd_data present the head entry whenever empty=0; rd_en=1 with empty=0 pops it at the next edge; rd_en while empty is ignored.
REQ-025 Push while full is dropped and sets sticky ovf; a simultaneous push and pop while full is accepted, and occupancy is unchanged.
REQ-026 Pointers are 3-bit and wrap 7->0; a 4-bit count drives empty (count==0) and full (count==8).
REQ-027 Reads remain legal in terminal states so the bench can drain the log after done.

Reset
REQ-028 resetb=0 at a ph1 edge: state RUN, cycle counter 0, done/pass/timeout 0, result 8'h00, wcount 0.
REQ-029 Reset also clears the FIFO: empty=1, full=0, ovf=0; rd_addr/rd_data 8'h00.
REQ-030 Reset asserted mid-run or in a terminal state discards all state; no write is captured on a reset edge.

Configuration
REQ-031 Macro RESULT_MAILBOX_TRACE_EN defined: trace FIFO and its ports are built as in REQ-023..027.
REQ-032 Macro undefined: no FIFO storage; empty is tied 1, full 0, ovf 0, rd_addr/rd_data 8'h00, and rd_en is ignored; all other behaviour is identical.

Verification
REQ-033 Reset, then write 8'h9D to 16'h0030 at cycle 50 -> next edge done=1, pass=1, timeout=0, result=8'h9D.
REQ-034 Write 8'h9C to 16'h0030 -> done=1, pass=0, result=8'h9C; a later write of 8'h9D leaves all outputs unchanged.
REQ-035 No WATCH_ADDR write for 220 cycles -> done=1, timeout=1, pass=0; a WATCH_ADDR write exactly at cycle 220 -> PASS instead.
REQ-036 (TRACE_EN) 10 writes to 16'h0000..0009 with data 8'h10..19 -> full=1, ovf=1; drain returns (00,10)..(07,17) in order, then empty=1; wcount=10.
REQ-037 Assert resetb=0 for one cycle after three logged writes -> all outputs back to reset values and FIFO empty; the run then restarts and passes.
REQ-038 (no TRACE_EN) Repeat REQ-036 -> empty stays 1, ovf 0, wcount=10.
